// File: rtl/rs_pkg.sv
// Shared constants and state encoding for the resize output packer.
package rs_pkg;

  localparam int FRAME_DIM       = 17;
  localparam int PIX_PER_WORD    = 4;
  localparam int WORDS_PER_FRAME = (FRAME_DIM * FRAME_DIM + PIX_PER_WORD - 1) / PIX_PER_WORD;
  localparam int PIX_CNT_W       = 9;
  localparam int RC_CNT_W        = 5;
  localparam int WORD_W          = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/resize_out_packer_if.sv
// Pixel input strobe and packed-word output handshake of the packer.
interface resize_out_packer_if;

  logic        I_VALID;
  logic [7:0]  I_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_DATA;
  logic        OUT_LAST;

  // Environment side: resize engine plus downstream consumer.
  modport master (
    output I_VALID, I_DATA, OUT_READY,
    input  OUT_VALID, OUT_DATA, OUT_LAST
  );

  // Packer side.
  modport slave (
    input  I_VALID, I_DATA, OUT_READY,
    output OUT_VALID, OUT_DATA, OUT_LAST
  );

endinterface

// File: rtl/rs_fifo.sv
// Synchronous FIFO with a registered head: out_valid/out_data always reflect
// the oldest stored entry, with no same-cycle bypass from push to output.
module rs_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             full,
  output logic             empty,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             pop, push_ok;

  // Flags, accepted push/pop and the head entry for the next cycle.
  always_comb begin
    empty   = (wr_ptr_reg == rd_ptr_reg);
    full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
              (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    pop     = out_valid_reg && pop_ready && !clr;
    // A full FIFO still takes a word if the head leaves in the same cycle.
    push_ok = push && !clr && (!full || pop);
    wr_ptr_next = push_ok ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next = pop     ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    if (wr_ptr_next == rd_ptr_next) begin
      out_data_next = '0;
    end else if (push_ok && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])) begin
      // The new head is the slot being written this cycle.
      out_data_next = push_data;
    end else begin
      out_data_next = mem[rd_ptr_next[AW-1:0]];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Pointers and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      out_valid_reg <= (wr_ptr_next != rd_ptr_next);
      out_data_reg  <= out_data_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: rtl/resize_out_packer.sv
// Packs 8-bit pixels from the resize engine into little-endian 32-bit words,
// tags the final word of each frame, and buffers words in an output FIFO.
module resize_out_packer
  import rs_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_DIM  = rs_pkg::FRAME_DIM
) (
  input  logic               clk,
  input  logic               RST_N,
  input  logic               START,
  resize_out_packer_if.slave bus,
  output logic               BUSY,
  output logic               ERR
);

  localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(FRAME_DIM * FRAME_DIM - 1);
  localparam logic [RC_CNT_W-1:0]  COL_LAST = RC_CNT_W'(FRAME_DIM - 1);

  state_t                state_reg;
  logic [PIX_CNT_W-1:0]  pix_cnt_reg;
  logic [RC_CNT_W-1:0]   col_cnt_reg;
  logic [RC_CNT_W-1:0]   row_cnt_reg;
  logic [WORD_W-1:0]     pack_reg;
  logic                  err_reg;
  logic                  busy_reg;

  logic [1:0]            lane;
  logic                  pix_take, pix_last, word_push;
  logic [WORD_W-1:0]     word_data;
  logic                  fifo_full, fifo_empty, fifo_valid, fifo_pop, overflow;
  logic [WORD_W:0]       fifo_out;

  // Accept a pixel only while collecting; a START in the same cycle wins.
  always_comb begin
    lane      = pix_cnt_reg[1:0];
    pix_take  = (state_reg == COLLECT) && bus.I_VALID && !START;
    pix_last  = pix_take && (pix_cnt_reg == LAST_PIX);
    word_push = pix_take && ((lane == 2'd3) || pix_last);
    fifo_pop  = fifo_valid && bus.OUT_READY;
    overflow  = word_push && fifo_full && !fifo_pop;
  end

  // Word being built this cycle: the incoming pixel lands in its lane.
  genvar gi;
  generate
    for (gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
      assign word_data[gi*8 +: 8] = (lane == 2'(gi)) ? bus.I_DATA : pack_reg[gi*8 +: 8];
    end
  endgenerate

  // Frame state machine, pixel/row/column counters, pack register and flags.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= IDLE;
      pix_cnt_reg <= '0;
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
      pack_reg    <= '0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else if (START) begin
      // New frame, or abort of the current one.
      state_reg   <= COLLECT;
      pix_cnt_reg <= '0;
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
      pack_reg    <= '0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b1;
    end else begin
      if (overflow) begin
        err_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          busy_reg <= 1'b0;
        end
        COLLECT: begin
          if (pix_take) begin
            // Cleared after each push so a partial final word has zero lanes.
            pack_reg <= word_push ? '0 : word_data;
            if (pix_last) begin
              pix_cnt_reg <= '0;
              col_cnt_reg <= '0;
              row_cnt_reg <= '0;
              state_reg   <= DRAIN;
            end else begin
              pix_cnt_reg <= pix_cnt_reg + 1'b1;
              if (col_cnt_reg == COL_LAST) begin
                col_cnt_reg <= '0;
                row_cnt_reg <= row_cnt_reg + 1'b1;
              end else begin
                col_cnt_reg <= col_cnt_reg + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          // An empty FIFO also ends the frame, so a dropped last word
          // cannot leave the block stuck busy.
          if ((fifo_pop && fifo_out[WORD_W]) || fifo_empty) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  rs_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (RST_N),
    .clr       (START),
    .push      (word_push),
    .push_data ({pix_last, word_data}),
    .pop_ready (bus.OUT_READY),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .out_valid (fifo_valid),
    .out_data  (fifo_out)
  );

  assign bus.OUT_VALID = fifo_valid;
  assign bus.OUT_DATA  = fifo_out[WORD_W-1:0];
  assign bus.OUT_LAST  = fifo_out[WORD_W];
  assign BUSY          = busy_reg;
  assign ERR           = err_reg;

endmodule

// File: tb/tb_resize_out_packer.sv
// Scoreboard bench for resize_out_packer: a frame model pushes expected words
// as pixels are driven; a monitor pops and compares on each transfer.
module tb_resize_out_packer;

  localparam int NPIX = 289;

  logic clk;
  logic RST_N;
  logic START;
  logic BUSY;
  logic ERR;

  resize_out_packer_if bus ();

  resize_out_packer #(
    .FIFO_DEPTH (8),
    .FRAME_DIM  (17)
  ) dut (
    .clk   (clk),
    .RST_N (RST_N),
    .START (START),
    .bus   (bus),
    .BUSY  (BUSY),
    .ERR   (ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q [$];
  int          rx_count;
  logic [31:0] first_word;
  logic [32:0] last_rx;
  bit          stall_pending;
  logic [32:0] stall_word;
  int          cyc;

  // Frame model state.
  bit          m_active;
  int          m_pix;
  int          m_words;
  int          m_cap;
  logic [31:0] m_pack;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_start();
    m_active = 1'b1;
    m_pix    = 0;
    m_words  = 0;
    m_pack   = '0;
  endtask

  task automatic model_pixel(input logic [7:0] d);
    int  lane;
    bit  last;
    if (!m_active) return;
    lane = m_pix % 4;
    last = (m_pix == NPIX - 1);
    m_pack[lane*8 +: 8] = d;
    if (lane == 3 || last) begin
      if (m_words < m_cap) exp_q.push_back({last, m_pack});
      m_words++;
      m_pack = '0;
    end
    if (last) m_active = 1'b0;
    m_pix++;
  endtask

  // One clock cycle of stimulus; returns 1 time unit after the active edge.
  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic st);
    bus.I_VALID = v;
    bus.I_DATA  = d;
    START       = st;
    if (st) begin
      exp_q.delete();
      rx_count = 0;
      model_start();
    end else if (v) begin
      model_pixel(d);
    end
    @(posedge clk);
    #1;
    START       = 1'b0;
    bus.I_VALID = 1'b0;
  endtask

  // Wait (bounded) for the scoreboard to empty and optionally for BUSY low.
  task automatic wait_drain(input bit toggle, input bit need_idle, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || (need_idle && BUSY)) && n < 3000) begin
      if (toggle) bus.OUT_READY = (cyc % 3 == 0);
      cyc++;
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_left"}, exp_q.size(), 0);
    if (need_idle) check_eq({tag, "_busy"}, BUSY, 0);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [32:0] e;
    if (RST_N && !START && bus.OUT_VALID) begin
      if (stall_pending) check_eq("hold_stable", {bus.OUT_LAST, bus.OUT_DATA}, stall_word);
      if (bus.OUT_READY) begin
        $display("word %0d: data=%08h last=%0b", rx_count, bus.OUT_DATA, bus.OUT_LAST);
        if (exp_q.size() == 0) begin
          check_eq("spurious_word", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_eq("word_data", bus.OUT_DATA, e[31:0]);
          check_eq("word_last", bus.OUT_LAST, e[32]);
        end
        if (rx_count == 0) first_word = bus.OUT_DATA;
        last_rx = {bus.OUT_LAST, bus.OUT_DATA};
        rx_count++;
        stall_pending = 1'b0;
      end else begin
        stall_pending = 1'b1;
        stall_word    = {bus.OUT_LAST, bus.OUT_DATA};
      end
    end else begin
      stall_pending = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    RST_N         = 1'b0;
    START         = 1'b0;
    bus.I_VALID   = 1'b0;
    bus.I_DATA    = '0;
    bus.OUT_READY = 1'b0;
    rx_count      = 0;
    first_word    = '0;
    last_rx       = '0;
    stall_pending = 1'b0;
    stall_word    = '0;
    cyc           = 0;
    m_active      = 1'b0;
    m_pix         = 0;
    m_words       = 0;
    m_cap         = 1000;
    m_pack        = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", bus.OUT_VALID, 0);
    check_eq("rst_data", bus.OUT_DATA, 0);
    check_eq("rst_last", bus.OUT_LAST, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_err", ERR, 0);
    RST_N = 1'b1;
    @(posedge clk);
    #1;

    // Full frame, back-to-back pixels, downstream always ready.
    bus.OUT_READY = 1'b1;
    m_cap = 1000;
    drive_cycle(1'b0, 8'h00, 1'b1);
    check_eq("t1_busy_start", BUSY, 1);
    for (int i = 0; i < NPIX; i++) begin
      drive_cycle(1'b1, 8'(i % 256), 1'b0);
      if (i == 2) check_eq("t1_no_word_yet", bus.OUT_VALID, 0);
      if (i == 3) check_eq("t1_latency", bus.OUT_VALID, 1);
    end
    wait_drain(1'b0, 1'b1, "t1");
    check_eq("t1_count", rx_count, 73);
    check_eq("t1_word0", first_word, 32'h03020100);
    check_eq("t1_word72", last_rx, {1'b1, 32'h00000020});
    check_eq("t1_err", ERR, 0);

    // Downstream stalled: first 8 words kept, 9th push overflows.
    bus.OUT_READY = 1'b0;
    m_cap = 8;
    drive_cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < NPIX; i++) begin
      drive_cycle(1'b1, 8'(i % 256), 1'b0);
      if (i == 34) check_eq("t2_err_before", ERR, 0);
      if (i == 35) begin
        check_eq("t2_err_set", ERR, 1);
        check_eq("t2_head_held", bus.OUT_DATA, 32'h03020100);
      end
    end
    bus.OUT_READY = 1'b1;
    wait_drain(1'b0, 1'b1, "t2");
    check_eq("t2_count", rx_count, 8);
    check_eq("t2_word0", first_word, 32'h03020100);

    // Ready 1-of-3 cycles, pixels with random gaps and values.
    m_cap = 1000;
    drive_cycle(1'b0, 8'h00, 1'b1);
    got = 0;
    while (got < NPIX) begin
      logic v;
      bus.OUT_READY = (cyc % 3 == 0);
      cyc++;
      v = ($urandom_range(0, 2) != 0);
      drive_cycle(v, 8'($urandom), 1'b0);
      if (v) got++;
    end
    wait_drain(1'b1, 1'b1, "t3");
    check_eq("t3_count", rx_count, 73);
    check_eq("t3_err", ERR, 0);
    check_eq("t3_last", last_rx[32], 1);

    // Abort after 100 pixels with words buffered, then a clean frame.
    bus.OUT_READY = 1'b0;
    m_cap = 8;
    drive_cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 100; i++) drive_cycle(1'b1, 8'(i % 256), 1'b0);
    check_eq("t4_valid_before", bus.OUT_VALID, 1);
    m_cap = 1000;
    drive_cycle(1'b1, 8'hAA, 1'b1);
    check_eq("t4_flushed", bus.OUT_VALID, 0);
    check_eq("t4_err_clr", ERR, 0);
    check_eq("t4_busy", BUSY, 1);
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < NPIX; i++) drive_cycle(1'b1, 8'((i + 7) % 256), 1'b0);
    wait_drain(1'b0, 1'b1, "t4");
    check_eq("t4_count", rx_count, 73);
    check_eq("t4_word0", first_word, 32'h0A090807);

    // Asynchronous reset mid-frame, then stray pixels without START.
    bus.OUT_READY = 1'b0;
    m_cap = 8;
    drive_cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 50; i++) drive_cycle(1'b1, 8'(i % 256), 1'b0);
    check_eq("t5_err_pre", ERR, 1);
    #2;
    RST_N = 1'b0;
    #1;
    check_eq("t5_valid", bus.OUT_VALID, 0);
    check_eq("t5_data", bus.OUT_DATA, 0);
    check_eq("t5_last", bus.OUT_LAST, 0);
    check_eq("t5_busy", BUSY, 0);
    check_eq("t5_err", ERR, 0);
    exp_q.delete();
    m_active = 1'b0;
    rx_count = 0;
    @(negedge clk);
    RST_N = 1'b1;
    @(posedge clk);
    #1;
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 40; i++) drive_cycle(1'b1, 8'(i), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_no_words", rx_count, 0);
    check_eq("t5_idle_valid", bus.OUT_VALID, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
